// File: rtl/bcd_score_pkg.sv
// ============================================================================
// bcd_score_pkg : shared types, constants and helpers for the BCD scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

package bcd_score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  // Elaboration-time conversion of a decimal value to four packed BCD digits.
  function automatic logic [15:0] dec_to_bcd(input int unsigned value);
    logic [15:0] result;
    int unsigned v;
    result = '0;
    v      = value;
    for (int d = 0; d < 4; d++) begin
      result[d*4 +: 4] = 4'(v % 10);
      v                = v / 10;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_scoreboard_bcd_add_sat.sv
// ============================================================================
// bcd_add_sat : combinational N-digit BCD adder with saturation at all-nines
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_add_sat
  import bcd_score_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic [NUM_DIGITS*4-1:0] score_in,
  input  logic [1:0]              addend,
  output logic [NUM_DIGITS*4-1:0] sum_out,
  output logic                    sat
);

  localparam logic [NUM_DIGITS*4-1:0] ALL_NINES = {NUM_DIGITS{BCD_NINE}};

  logic [NUM_DIGITS*4-1:0] sum;
  logic [4:0]              digit_sum;
  logic                    carry;

  always_comb begin
    sum       = '0;
    digit_sum = '0;
    carry     = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      digit_sum = {1'b0, score_in[d*4 +: 4]} + {4'b0, carry}
                + ((d == 0) ? {3'b0, addend} : 5'd0);
      if (digit_sum > 5'd9) begin
        sum[d*4 +: 4] = 4'(digit_sum - 5'd10);
        carry         = 1'b1;
      end else begin
        sum[d*4 +: 4] = digit_sum[3:0];
        carry         = 1'b0;
      end
    end
    // A carry out of the top digit means the true sum is unrepresentable.
    if (carry) begin
      sum = ALL_NINES;
    end
  end

  assign sum_out = sum;
  assign sat     = (sum == ALL_NINES);

endmodule

`default_nettype wire

// File: rtl/bcd_scoreboard.sv
// ============================================================================
// bcd_scoreboard : multi-player BCD score keeper with win detection
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_scoreboard
  import bcd_score_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_DIGITS  = 2,
  parameter int WIN_SCORE   = 21,
  parameter int PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                goal,
  input  logic [PW-1:0]                       player,
  input  logic [1:0]                          points,
  output logic [NUM_PLAYERS*NUM_DIGITS*4-1:0] score,
  output logic [NUM_PLAYERS-1:0]              sat,
  output logic                                game_over,
  output logic [PW-1:0]                       winner,
  output logic                                accept
);

  localparam int SW = NUM_DIGITS * 4;
  localparam logic [15:0]   WIN_BCD_FULL = dec_to_bcd(WIN_SCORE);
  localparam logic [SW-1:0] WIN_BCD      = WIN_BCD_FULL[SW-1:0];

  state_t                            state_q;
  state_t                            state_d;
  logic [NUM_PLAYERS-1:0][SW-1:0]    scores_q;
  logic [NUM_PLAYERS-1:0]            sat_q;
  logic [PW-1:0]                     winner_q;
  logic                              accept_q;
  logic                              goal_q;

  logic                              goal_event;
  logic                              player_ok;
  logic [SW-1:0]                     sel_score;
  logic [SW-1:0]                     new_score;
  logic                              new_sat;
  logic                              apply;
  logic                              clear;
  logic                              win;

  assign goal_event = goal & ~goal_q;

  // Index range check is only needed when the index width can exceed the player count.
  if ((1 << PW) == NUM_PLAYERS) begin : g_full_range
    assign player_ok = 1'b1;
  end else begin : g_range_check
    assign player_ok = (int'(player) < NUM_PLAYERS);
  end

  always_comb begin
    sel_score = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (PW'(p) == player) begin
        sel_score = scores_q[p];
      end
    end
  end

  bcd_add_sat #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_add (
    .score_in (sel_score),
    .addend   (points),
    .sum_out  (new_score),
    .sat      (new_sat)
  );

  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    clear   = 1'b0;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (!enable) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (goal_event && player_ok) begin
          apply = 1'b1;
          // Packed BCD of equal width orders the same as its decimal value.
          if ((WIN_SCORE != 0) && (new_score >= WIN_BCD)) begin
            state_d = OVER;
            win     = 1'b1;
          end
        end
      end
      OVER: begin
        if (!enable) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      goal_q   <= 1'b0;
      scores_q <= '0;
      sat_q    <= '0;
      winner_q <= '0;
      accept_q <= 1'b0;
    end else begin
      goal_q   <= goal;
      accept_q <= apply;
      if (clear) begin
        scores_q <= '0;
        sat_q    <= '0;
        winner_q <= '0;
      end else if (apply) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (PW'(p) == player) begin
            scores_q[p] <= new_score;
            sat_q[p]    <= new_sat;
          end
        end
        if (win) begin
          winner_q <= player;
        end
      end
    end
  end

  assign score     = scores_q;
  assign sat       = sat_q;
  assign winner    = winner_q;
  assign accept    = accept_q;
  assign game_over = (state_q == OVER);

endmodule

`default_nettype wire

// File: tb/tb_bcd_scoreboard.sv
// ============================================================================
// tb_bcd_scoreboard : directed self-checking bench for bcd_scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_scoreboard;

  logic clk = 1'b0;
  logic rst;

  // Instance A: 2 players, 2 digits, win at 21
  logic        a_enable, a_goal;
  logic [0:0]  a_player;
  logic [1:0]  a_points;
  logic [15:0] a_score;
  logic [1:0]  a_sat;
  logic        a_game_over;
  logic [0:0]  a_winner;
  logic        a_accept;

  // Instance B: 3 players, 2 digits, win detection disabled
  logic        b_enable, b_goal;
  logic [1:0]  b_player;
  logic [1:0]  b_points;
  logic [23:0] b_score;
  logic [2:0]  b_sat;
  logic        b_game_over;
  logic [1:0]  b_winner;
  logic        b_accept;

  int n_total = 0;
  int n_pass  = 0;
  logic last_acc;

  always #5 clk = ~clk;

  bcd_scoreboard #(.NUM_PLAYERS(2), .NUM_DIGITS(2), .WIN_SCORE(21)) dut_a (
    .clk(clk), .rst(rst), .enable(a_enable), .goal(a_goal), .player(a_player),
    .points(a_points), .score(a_score), .sat(a_sat), .game_over(a_game_over),
    .winner(a_winner), .accept(a_accept)
  );

  bcd_scoreboard #(.NUM_PLAYERS(3), .NUM_DIGITS(2), .WIN_SCORE(0)) dut_b (
    .clk(clk), .rst(rst), .enable(b_enable), .goal(b_goal), .player(b_player),
    .points(b_points), .score(b_score), .sat(b_sat), .game_over(b_game_over),
    .winner(b_winner), .accept(b_accept)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One goal event: rise, sample accept after the edge, then fall for a cycle.
  task automatic goal_a(input logic p, input logic [1:0] pts);
    a_player = p; a_points = pts; a_goal = 1'b1;
    tick();
    last_acc = a_accept;
    a_goal = 1'b0;
    tick();
  endtask

  task automatic goal_b(input logic [1:0] p, input logic [1:0] pts);
    b_player = p; b_points = pts; b_goal = 1'b1;
    tick();
    last_acc = b_accept;
    b_goal = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_enable = 1'b1; a_goal = 1'b0; a_player = '0; a_points = '0;
    b_enable = 1'b1; b_goal = 1'b0; b_player = '0; b_points = '0;
    last_acc = 1'b0;
    tick(); tick();
    check("rst_score", 32'(a_score), 32'h0);
    check("rst_over",  32'(a_game_over), 32'h0);
    check("rst_acc",   32'(a_accept), 32'h0);
    check("rst_sat",   32'(a_sat), 32'h0);
    rst = 1'b0;
    tick();  // IDLE -> PLAY

    // Carry and points
    goal_a(1'b0, 2'd3); goal_a(1'b0, 2'd3); goal_a(1'b0, 2'd2);
    check("p0_08", 32'(a_score), 32'h0008);
    a_player = 1'b0; a_points = 2'd3; a_goal = 1'b1;
    tick();
    check("p0_11", 32'(a_score), 32'h0011);
    check("p0_11_acc", 32'(a_accept), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_acc", 32'(a_accept), 32'h0);
    end
    check("hold_score", 32'(a_score), 32'h0011);
    a_goal = 1'b0;
    tick();

    // Win for player 1
    for (int i = 0; i < 6; i++) goal_a(1'b1, 2'd3);
    goal_a(1'b1, 2'd1);
    check("p1_19", 32'(a_score), 32'h1911);
    check("p1_19_over", 32'(a_game_over), 32'h0);
    goal_a(1'b1, 2'd2);
    check("win_score", 32'(a_score), 32'h2111);
    check("win_over",  32'(a_game_over), 32'h1);
    check("win_who",   32'(a_winner), 32'h1);
    goal_a(1'b0, 2'd3);
    check("over_acc",   32'(last_acc), 32'h0);
    check("over_score", 32'(a_score), 32'h2111);

    // Enable priority: drop enable with a goal edge from OVER
    a_player = 1'b0; a_points = 2'd1; a_goal = 1'b1; a_enable = 1'b0;
    tick();
    check("dis_score", 32'(a_score), 32'h0);
    check("dis_over",  32'(a_game_over), 32'h0);
    check("dis_acc",   32'(a_accept), 32'h0);
    a_enable = 1'b1;
    tick(); tick();  // PLAY with goal still held high
    check("held_acc",   32'(a_accept), 32'h0);
    check("held_score", 32'(a_score), 32'h0);
    a_goal = 1'b0;
    tick();
    goal_a(1'b0, 2'd1);
    check("retoggle_acc",   32'(last_acc), 32'h1);
    check("retoggle_score", 32'(a_score), 32'h0001);
    a_goal = 1'b1; a_enable = 1'b0;
    tick();
    check("play_dis_score", 32'(a_score), 32'h0);
    check("play_dis_acc",   32'(a_accept), 32'h0);
    a_goal = 1'b0; a_enable = 1'b1;
    tick(); tick();

    // Reset in the edge cycle discards the event
    a_goal = 1'b1; rst = 1'b1;
    tick();
    check("rst_evt_acc",   32'(a_accept), 32'h0);
    check("rst_evt_score", 32'(a_score), 32'h0);
    rst = 1'b0; a_goal = 1'b0;
    tick(); tick();

    // Saturation on instance B
    for (int i = 0; i < 32; i++) goal_b(2'd1, 2'd3);
    goal_b(2'd1, 2'd2);
    check("b_p1_98", 32'(b_score), 32'h009800);
    check("b_sat_98", 32'(b_sat), 32'h0);
    goal_b(2'd1, 2'd3);
    check("b_p1_99", 32'(b_score), 32'h009900);
    check("b_sat_99", 32'(b_sat), 32'h2);
    goal_b(2'd1, 2'd2);
    check("b_sat_hold", 32'(b_score), 32'h009900);
    check("b_sat_acc",  32'(last_acc), 32'h1);
    check("b_no_win",   32'(b_game_over), 32'h0);

    // Illegal player index
    goal_b(2'd3, 2'd1);
    check("b_bad_acc",   32'(last_acc), 32'h0);
    check("b_bad_score", 32'(b_score), 32'h009900);
    goal_b(2'd2, 2'd1);
    check("b_p2_acc",   32'(last_acc), 32'h1);
    check("b_p2_score", 32'(b_score), 32'h019900);

    // points=0 still accepted
    goal_b(2'd0, 2'd0);
    check("b_zero_acc",   32'(last_acc), 32'h1);
    check("b_zero_score", 32'(b_score), 32'h019900);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
